l1_mem_arbiter: RTL and testbench

Two-port arbiter between the instruction cache and data cache miss ports and the single shared memory port (L2 / physical memory). Sits directly downstream of the I-cache and D-cache that service the CPU datapath's `imem_*` and `dmem_*` buses. It accepts line-sized read and write requests from both caches. It grants one request at a time with round-robin fairness, issues the request on registered downstream outputs, and routes the response or retry back to the owner.

---
 rtl/l1_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin arbiter joining the I-cache and D-cache
// miss ports onto a single registered memory port.
module l1_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [DATA_W-1:0] i_dat_w,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              i_resp,
    output logic              i_retry,
    output logic [DATA_W-1:0] i_dat_r,

    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_w,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_resp,
    output logic              d_retry,
    output logic [DATA_W-1:0] d_dat_r,

    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_adr,
    output logic [DATA_W-1:0] m_dat_w,
    output logic [SEL_W-1:0]  m_sel,
    input  logic              m_resp,
    input  logic              m_retry,
    input  logic [DATA_W-1:0] m_dat_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_REPLY
    } state_t;

    state_t              r_state;
    logic                r_last_d;
    logic                r_abort;

    logic                r_m_cyc;
    logic                r_m_stb;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_adr;
    logic [DATA_W-1:0]   r_m_dat_w;
    logic [SEL_W-1:0]    r_m_sel;

    logic                r_i_resp;
    logic                r_i_retry;
    logic [DATA_W-1:0]   r_i_dat;
    logic                r_d_resp;
    logic                r_d_retry;
    logic [DATA_W-1:0]   r_d_dat;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_any_req;
    logic                w_pick_d;
    logic                w_own_d;
    logic                w_own_cyc;
    logic                w_done;
    logic                w_quiet;

    assign w_i_req   = i_cyc & i_stb;
    assign w_d_req   = d_cyc & d_stb;
    assign w_any_req = w_i_req | w_d_req;

    // On a tie the side that did not win last time gets the port.
    assign w_pick_d  = w_d_req & (~w_i_req | ~r_last_d);

    assign w_own_d   = (r_state == S_BUSY_D);
    assign w_own_cyc = w_own_d ? d_cyc : i_cyc;
    assign w_done    = m_resp | m_retry;

    // An owner that let go of cyc gets no reply pulse.
    assign w_quiet   = r_abort | ~w_own_cyc;

    assign m_cyc   = r_m_cyc;
    assign m_stb   = r_m_stb;
    assign m_we    = r_m_we;
    assign m_adr   = r_m_adr;
    assign m_dat_w = r_m_dat_w;
    assign m_sel   = r_m_sel;

    assign i_resp  = r_i_resp;
    assign i_retry = r_i_retry;
    assign i_dat_r = r_i_dat;
    assign d_resp  = r_d_resp;
    assign d_retry = r_d_retry;
    assign d_dat_r = r_d_dat;

    // Arbitration FSM with all downstream and reply outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b0;
            r_abort   <= 1'b0;
            r_m_cyc   <= 1'b0;
            r_m_stb   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_adr   <= '0;
            r_m_dat_w <= '0;
            r_m_sel   <= '0;
            r_i_resp  <= 1'b0;
            r_i_retry <= 1'b0;
            r_i_dat   <= '0;
            r_d_resp  <= 1'b0;
            r_d_retry <= 1'b0;
            r_d_dat   <= '0;
        end else begin
            r_i_resp  <= 1'b0;
            r_i_retry <= 1'b0;
            r_d_resp  <= 1'b0;
            r_d_retry <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_d <= w_pick_d;
                        r_abort  <= 1'b0;
                        r_m_cyc  <= 1'b1;
                        r_m_stb  <= 1'b1;
                        if (w_pick_d) begin
                            r_m_we    <= d_we;
                            r_m_adr   <= d_adr;
                            r_m_dat_w <= d_dat_w;
                            r_m_sel   <= d_sel;
                            r_state   <= S_BUSY_D;
                        end else begin
                            r_m_we    <= i_we;
                            r_m_adr   <= i_adr;
                            r_m_dat_w <= i_dat_w;
                            r_m_sel   <= i_sel;
                            r_state   <= S_BUSY_I;
                        end
                    end
                end

                S_BUSY_I, S_BUSY_D: begin
                    if (w_done) begin
                        r_m_cyc <= 1'b0;
                        r_m_stb <= 1'b0;
                        if (m_resp) begin
                            if (w_own_d) begin
                                r_d_dat <= m_dat_r;
                            end else begin
                                r_i_dat <= m_dat_r;
                            end
                        end
                        if (w_quiet) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_REPLY;
                            if (w_own_d) begin
                                r_d_resp  <= m_resp;
                                r_d_retry <= ~m_resp;
                            end else begin
                                r_i_resp  <= m_resp;
                                r_i_retry <= ~m_resp;
                            end
                        end
                    end else if (!w_own_cyc) begin
                        r_abort <= 1'b1;
                    end
                end

                S_REPLY: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized scoreboard bench for l1_mem_arbiter: a transaction-level
// memory/requester model predicts grants and reply pulses.
module tb_l1_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;

    logic          i_cyc, i_stb, i_we;
    logic [AW-1:0] i_adr;
    logic [DW-1:0] i_dat_w;
    logic [SW-1:0] i_sel;
    logic          i_resp, i_retry;
    logic [DW-1:0] i_dat_r;

    logic          d_cyc, d_stb, d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_dat_w;
    logic [SW-1:0] d_sel;
    logic          d_resp, d_retry;
    logic [DW-1:0] d_dat_r;

    logic          m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat_w;
    logic [SW-1:0] m_sel;
    logic          m_resp, m_retry;
    logic [DW-1:0] m_dat_r;

    l1_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .SEL_W  (SW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_cyc   (i_cyc),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_adr   (i_adr),
        .i_dat_w (i_dat_w),
        .i_sel   (i_sel),
        .i_resp  (i_resp),
        .i_retry (i_retry),
        .i_dat_r (i_dat_r),
        .d_cyc   (d_cyc),
        .d_stb   (d_stb),
        .d_we    (d_we),
        .d_adr   (d_adr),
        .d_dat_w (d_dat_w),
        .d_sel   (d_sel),
        .d_resp  (d_resp),
        .d_retry (d_retry),
        .d_dat_r (d_dat_r),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_w (m_dat_w),
        .m_sel   (m_sel),
        .m_resp  (m_resp),
        .m_retry (m_retry),
        .m_dat_r (m_dat_r)
    );

    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endtask

    typedef struct {
        int            d;
        bit            retry;
        logic [DW-1:0] data;
        int unsigned   at;
    } exp_t;

    exp_t sbq[$];

    // Monitor: every reply pulse must match the oldest predicted reply.
    always @(negedge clk) begin
        logic [3:0] bits;
        logic [3:0] ebits;
        exp_t       e;
        bits = {i_resp, i_retry, d_resp, d_retry};
        if (bits != 4'b0000) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", DW'(bits), '0);
            end else begin
                e = sbq.pop_front();
                if (e.d == 0) ebits = e.retry ? 4'b0100 : 4'b1000;
                else          ebits = e.retry ? 4'b0001 : 4'b0010;
                chk("pulse_kind", DW'(bits), DW'(ebits));
                chk("pulse_cycle", DW'(cyc_n), DW'(e.at));
                if (!e.retry) begin
                    chk("rdata", (e.d != 0) ? d_dat_r : i_dat_r, e.data);
                end
            end
        end
    end

    // Requester model state (index 0 = I-cache, 1 = D-cache).
    bit            act[2]    = '{0, 0};
    logic [AW-1:0] radr[2];
    bit            rwe[2]    = '{0, 0};
    logic [DW-1:0] rdat[2];
    logic [SW-1:0] rsel[2];
    int            wait_c[2] = '{0, 0};

    // Memory model state.
    bit            mbusy     = 0;
    bit            mabort    = 0;
    int            own       = 0;
    int            last      = 0;
    int            lat       = 0;
    int unsigned   free_edge = 0;

    // Knobs for directed sequences; -1 / 0 means random.
    bit            gen_en    = 0;
    int            f_lat     = -1;
    int            f_kind    = 0;
    int            f_abort   = -1;
    bit            f_data_en = 0;
    logic [DW-1:0] f_data    = '0;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_req();
        i_cyc   = act[0];
        i_stb   = act[0];
        i_we    = rwe[0];
        i_adr   = radr[0];
        i_dat_w = rdat[0];
        i_sel   = rsel[0];
        d_cyc   = act[1];
        d_stb   = act[1];
        d_we    = rwe[1];
        d_adr   = radr[1];
        d_dat_w = rdat[1];
        d_sel   = rsel[1];
    endtask

    task automatic set_req(input int s, input logic [AW-1:0] a,
                           input bit we, input logic [DW-1:0] dw,
                           input logic [SW-1:0] sel);
        act[s]    = 1;
        wait_c[s] = 0;
        radr[s]   = a;
        rwe[s]    = we;
        rdat[s]   = dw;
        rsel[s]   = sel;
    endtask

    // One clock of the combined requester + memory model.
    task automatic step();
        bit rq0;
        bit rq1;
        bit pulse;
        bit blocked;
        int k;
        @(posedge clk);
        #2;
        rq0 = i_cyc & i_stb;
        rq1 = d_cyc & d_stb;
        if (!mbusy) begin
            chk("grant_timing", DW'(m_stb),
                DW'((cyc_n >= free_edge) && (rq0 || rq1)));
            if (m_stb && (rq0 || rq1)) begin
                if (rq0 && rq1) own = 1 - last;
                else            own = rq1 ? 1 : 0;
                last   = own;
                mbusy  = 1;
                mabort = 0;
                lat    = (f_lat >= 0) ? f_lat : $urandom_range(0, 3);
                chk("m_cyc", DW'(m_cyc), DW'(1));
                chk("m_adr", DW'(m_adr), DW'(radr[own]));
                chk("m_we", DW'(m_we), DW'(rwe[own]));
                chk("m_sel", DW'(m_sel), DW'(rsel[own]));
                chk("m_dat_w", m_dat_w, rdat[own]);
            end
        end else begin
            chk("m_stb_hold", DW'(m_stb), DW'(1));
        end

        m_resp  = 0;
        m_retry = 0;
        if (mbusy) begin
            if (lat == 0) begin
                if (f_kind != 0) k = f_kind;
                else if ($urandom_range(0, 7) < 2) k = 2;
                else if ($urandom_range(0, 7) == 0) k = 3;
                else k = 1;
                m_resp  = (k != 2);
                m_retry = (k != 1);
                m_dat_r = f_data_en ? f_data : rnd128();
                if (!mabort) begin
                    sbq.push_back('{d: own, retry: (k == 2),
                                    data: m_dat_r, at: cyc_n + 1});
                end
                free_edge = cyc_n + (mabort ? 2 : 3);
                mbusy = 0;
            end else begin
                lat--;
                if (!mabort && ((f_abort >= 0) ? (lat == f_abort)
                                : (gen_en && $urandom_range(0, 19) == 0))) begin
                    mabort   = 1;
                    act[own] = 0;
                end
            end
        end else if ($urandom_range(0, 7) == 0) begin
            m_resp  = $urandom_range(0, 1);
            m_retry = ~m_resp;
            m_dat_r = rnd128();
        end

        for (int s = 0; s < 2; s++) begin
            pulse   = (s == 1) ? (d_resp | d_retry) : (i_resp | i_retry);
            blocked = mbusy && mabort && (own == s);
            if (act[s]) begin
                if (pulse) begin
                    act[s] = 0;
                end else begin
                    wait_c[s]++;
                    if (wait_c[s] > 300) begin
                        chk("req_timeout", DW'(wait_c[s]), DW'(300));
                        act[s] = 0;
                    end
                end
            end else if (gen_en && !blocked && $urandom_range(0, 2) == 0) begin
                set_req(s, AW'($urandom()), 1'($urandom_range(0, 1)),
                        rnd128(), SW'($urandom()));
            end
        end
        drive_req();
    endtask

    task automatic reset_knobs();
        f_lat     = -1;
        f_kind    = 0;
        f_abort   = -1;
        f_data_en = 0;
    endtask

    initial begin
        rst     = 1;
        m_resp  = 0;
        m_retry = 0;
        m_dat_r = '0;
        for (int s = 0; s < 2; s++) begin
            radr[s] = '0;
            rdat[s] = '0;
            rsel[s] = '0;
        end
        drive_req();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_cyc", DW'(m_cyc), '0);
        chk("rst_m_stb", DW'(m_stb), '0);
        chk("rst_m_we", DW'(m_we), '0);
        chk("rst_m_adr", DW'(m_adr), '0);
        chk("rst_m_sel", DW'(m_sel), '0);
        chk("rst_m_dat_w", m_dat_w, '0);
        chk("rst_pulses", DW'({i_resp, i_retry, d_resp, d_retry}), '0);
        chk("rst_i_dat_r", i_dat_r, '0);
        chk("rst_d_dat_r", d_dat_r, '0);
        rst       = 0;
        last      = 0;
        free_edge = cyc_n + 1;

        // Single I read, memory answers three cycles after m_stb.
        f_lat     = 3;
        f_kind    = 1;
        f_data_en = 1;
        f_data    = {16{8'hA5}};
        set_req(0, 16'h1230, 0, rnd128(), '1);
        drive_req();
        repeat (10) step();

        // Tie after reset: D then I; next tie goes to D again.
        reset_knobs();
        f_lat  = 1;
        f_kind = 1;
        set_req(0, 16'h2000, 0, rnd128(), '1);
        set_req(1, 16'h3000, 0, rnd128(), '1);
        drive_req();
        repeat (14) step();
        set_req(0, 16'h2010, 0, rnd128(), '1);
        set_req(1, 16'h3010, 0, rnd128(), '1);
        drive_req();
        repeat (14) step();

        // D write with partial byte enables.
        f_lat = 2;
        set_req(1, 16'h4560, 1,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_DEAD, 16'h00FF);
        drive_req();
        repeat (10) step();

        // Retry on I with D pending: D must be granted next.
        f_kind = 2;
        set_req(0, 16'h5000, 0, rnd128(), '1);
        drive_req();
        step();
        set_req(1, 16'h6000, 0, rnd128(), '1);
        drive_req();
        repeat (12) step();

        // I abandons its request while the memory is still working.
        f_kind  = 1;
        f_lat   = 4;
        f_abort = 2;
        set_req(0, 16'h7000, 0, rnd128(), '1);
        drive_req();
        repeat (12) step();

        // Random traffic.
        reset_knobs();
        gen_en = 1;
        repeat (3000) step();
        gen_en = 0;
        repeat (60) step();
        chk("drain_queue", DW'(sbq.size()), '0);

        // Reset while the D-cache transaction is outstanding.
        f_lat = 20;
        set_req(1, 16'h4440, 0, rnd128(), '1);
        drive_req();
        for (int n = 0; n < 6 && !mbusy; n++) step();
        chk("rst_setup_busy", DW'(m_stb), DW'(1));
        @(posedge clk);
        #2;
        rst     = 1;
        m_resp  = 0;
        m_retry = 0;
        @(posedge clk);
        #2;
        chk("mrst_m_cyc", DW'(m_cyc), '0);
        chk("mrst_m_stb", DW'(m_stb), '0);
        chk("mrst_m_we", DW'(m_we), '0);
        chk("mrst_m_adr", DW'(m_adr), '0);
        chk("mrst_m_sel", DW'(m_sel), '0);
        chk("mrst_m_dat_w", m_dat_w, '0);
        chk("mrst_pulses", DW'({i_resp, i_retry, d_resp, d_retry}), '0);
        chk("mrst_d_dat_r", d_dat_r, '0);
        rst       = 0;
        act[1]    = 0;
        drive_req();
        m_resp    = 1;
        m_dat_r   = rnd128();
        mbusy     = 0;
        last      = 0;
        free_edge = cyc_n + 1;
        reset_knobs();
        @(posedge clk);
        #2;
        m_resp = 0;
        chk("late_resp_ignored", DW'(d_resp), '0);
        chk("late_resp_no_data", d_dat_r, '0);
        repeat (6) step();
        chk("final_queue", DW'(sbq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
